shifter_pipe: RTL and testbench
===============================

SHIFTER_PIPE -- requirements
Module: shifter_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width; legal values 8, 16, 32, 64.
REQ-002 SHALL have derived parameter SAW = log2(WIDTH), default 5, shift-amount width and pipeline depth.
REQ-003 SHALL have port Clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port Clrn  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port In_valid  input  1  an operand set is presented this cycle.
REQ-006 SHALL have port In_ready  output  1  the block accepts an operand set this cycle.
REQ-007 SHALL have port X  input  WIDTH  operand.
REQ-008 SHALL have port Sa  input  SAW  shift amount, 0..WIDTH-1.
REQ-009 SHALL have port Op  input  2  mode: 00 SLL, 01 SRL, 10 SRA, 11 ROR (rotate right).
REQ-010 SHALL have port Out_valid  output  1  Sh holds a result.
REQ-011 SHALL have port Out_ready  input  1  the consumer takes the result this cycle.
REQ-012 SHALL have port Sh  output  WIDTH  result.
REQ-013 SHALL have port Busy  output  1  at least one pipeline stage holds a valid entry.

Function
REQ-014 SHALL implement SAW registered stages; stage k (k=0..SAW-1) conditionally shifts by 2^(SAW-1-k) per Sa bit SAW-1-k, largest step first.
REQ-015 Each stage SHALL register data, remaining Sa bits, Op and a valid bit.
REQ-016 SLL SHALL fill vacated bits with 0; SRL with 0; SRA with the operand MSB captured at acceptance; ROR SHALL wrap shifted-out LSBs into the MSBs.
REQ-017 Sa=0 SHALL return X unchanged in every mode.
REQ-018 Advance SHALL be defined as (!Out_valid) | Out_ready; In_ready SHALL equal Advance, combinationally.
REQ-019 An operand set SHALL be accepted on a rising edge iff In_valid & In_ready.
REQ-020 When Advance=1, every stage SHALL load from its predecessor, and stage 0 SHALL load the new operand set with valid = In_valid.
REQ-021 When Advance=0, all stages SHALL hold data and valid unchanged; X, Sa and Op SHALL be ignored.
REQ-022 Latency SHALL be exactly SAW cycles from acceptance to Out_valid=1 with no stall; throughput SHALL be one result per cycle.
REQ-023 Bubbles (In_valid=0 while advancing) SHALL propagate as invalid entries; results SHALL leave in acceptance order, none dropped or duplicated.
REQ-024 Out_valid and Sh SHALL be the last stage's registered valid and data; Sh SHALL remain stable while Out_valid=1 and Out_ready=0.
REQ-025 Busy SHALL be the OR of all stage valid bits.
REQ-026 Simultaneous acceptance and output consumption in one cycle SHALL both take effect.

Reset
REQ-027 Clrn=0 SHALL asynchronously clear every stage valid bit and data register to 0, so Out_valid=0, Sh=0 and Busy=0.
REQ-028 Reset mid-operation SHALL discard all in-flight entries; In_ready SHALL be 1 during and after reset.
REQ-029 The first rising edge with Clrn=1 SHALL be able to accept an operand set.

Verification (WIDTH=32)
REQ-030 SLL: X=0x00000001, Sa=2, Op=00, Out_ready=1 -> after 5 cycles Out_valid=1, Sh=0x00000004.
REQ-031 SRA/SRL: X=0x80000010, Sa=2, Op=10 -> Sh=0xE0000004; same with Op=01 -> Sh=0x20000004.
REQ-032 ROR: X=0x00000003, Sa=1, Op=11 -> Sh=0x80000001; Sa=0 in any mode -> Sh=X.
REQ-033 Back-pressure: stream 8 back-to-back operands, hold Out_ready=0 for 3 cycles mid-stream -> In_ready=0 during the stall, Sh held stable, all 8 results in order, none lost.
REQ-034 Reset: drop Clrn with 3 entries in flight -> Out_valid, Busy and Sh immediately 0; after release no stale result appears.
REQ-035 Parameter sweep: WIDTH=8 and WIDTH=64, randomised X/Sa/Op against a reference model -> latency 3 and 6 respectively, all results correct.

Source files
------------

// File: rtl/shifter_pipe.sv
// Pipelined barrel shifter: one registered stage per shift-amount bit, largest step first.
// A single valid/ready pair with global stall; results leave in acceptance order.
module shifter_pipe #(
    parameter int WIDTH = 32,
    parameter int SAW   = $clog2(WIDTH)
) (
    input  logic             Clk,
    input  logic             Clrn,
    input  logic             In_valid,
    output logic             In_ready,
    input  logic [WIDTH-1:0] X,
    input  logic [SAW-1:0]   Sa,
    input  logic [1:0]       Op,
    output logic             Out_valid,
    input  logic             Out_ready,
    output logic [WIDTH-1:0] Sh,
    output logic             Busy
);

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;

    logic [WIDTH-1:0] data_q [SAW];
    logic [SAW-1:0]   vld_q;
    logic [SAW-1:0]   sa_q   [SAW-1];
    logic [1:0]       op_q   [SAW-1];

    logic [WIDTH-1:0] src_d  [SAW];
    logic [WIDTH-1:0] nxt_d  [SAW];
    logic [SAW-1:0]   src_sa [SAW];
    logic [1:0]       src_op [SAW];
    logic [SAW-1:0]   src_v;
    logic             advance;

    // SRA fills from the current MSB: earlier SRA stages never change it, so it is
    // always the operand MSB captured at acceptance.
    function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] d,
                                                    input logic [1:0] op,
                                                    input int step);
        case (op)
            OP_SLL:  return d << step;
            OP_SRL:  return d >> step;
            OP_SRA:  return WIDTH'($signed(d) >>> step);
            default: return (d >> step) | (d << (WIDTH - step));
        endcase
    endfunction

    assign advance   = !vld_q[SAW-1] | Out_ready;
    assign In_ready  = advance;
    assign Out_valid = vld_q[SAW-1];
    assign Sh        = data_q[SAW-1];
    assign Busy      = |vld_q;

    always_comb begin
        src_d[0]  = X;
        src_sa[0] = Sa;
        src_op[0] = Op;
        src_v[0]  = In_valid;
        for (int k = 1; k < SAW; k++) begin
            src_d[k]  = data_q[k-1];
            src_sa[k] = sa_q[k-1];
            src_op[k] = op_q[k-1];
            src_v[k]  = vld_q[k-1];
        end
    end

    // Remaining shift bits are kept left-aligned, so each stage tests the MSB.
    always_comb begin
        for (int k = 0; k < SAW; k++) begin
            nxt_d[k] = src_d[k];
            if (src_sa[k][SAW-1])
                nxt_d[k] = shift_step(src_d[k], src_op[k], 1 << (SAW - 1 - k));
        end
    end

    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            vld_q <= '0;
            for (int k = 0; k < SAW; k++)
                data_q[k] <= '0;
            for (int k = 0; k < SAW - 1; k++) begin
                sa_q[k] <= '0;
                op_q[k] <= '0;
            end
        end else if (advance) begin
            vld_q <= src_v;
            for (int k = 0; k < SAW; k++)
                data_q[k] <= nxt_d[k];
            for (int k = 0; k < SAW - 1; k++) begin
                sa_q[k] <= {src_sa[k][SAW-2:0], 1'b0};
                op_q[k] <= src_op[k];
            end
        end
    end

endmodule

// File: tb/tb_shifter_pipe.sv
// Directed bench for shifter_pipe at WIDTH 8, 32 and 64: modes, latency,
// back-pressure ordering and mid-flight reset.
module tb_shifter_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic        iv8 = 0,  ordy8 = 1,  irdy8,  ov8,  busy8;
    logic [7:0]  x8 = 0,   sh8;
    logic [2:0]  sa8 = 0;
    logic [1:0]  op8 = 0;

    logic        iv32 = 0, ordy32 = 1, irdy32, ov32, busy32;
    logic [31:0] x32 = 0,  sh32;
    logic [4:0]  sa32 = 0;
    logic [1:0]  op32 = 0;

    logic        iv64 = 0, ordy64 = 1, irdy64, ov64, busy64;
    logic [63:0] x64 = 0,  sh64;
    logic [5:0]  sa64 = 0;
    logic [1:0]  op64 = 0;

    shifter_pipe #(.WIDTH(8)) u_w8 (
        .Clk(clk), .Clrn(rst_n), .In_valid(iv8), .In_ready(irdy8), .X(x8), .Sa(sa8),
        .Op(op8), .Out_valid(ov8), .Out_ready(ordy8), .Sh(sh8), .Busy(busy8));

    shifter_pipe #(.WIDTH(32)) u_w32 (
        .Clk(clk), .Clrn(rst_n), .In_valid(iv32), .In_ready(irdy32), .X(x32), .Sa(sa32),
        .Op(op32), .Out_valid(ov32), .Out_ready(ordy32), .Sh(sh32), .Busy(busy32));

    shifter_pipe #(.WIDTH(64)) u_w64 (
        .Clk(clk), .Clrn(rst_n), .In_valid(iv64), .In_ready(irdy64), .X(x64), .Sa(sa64),
        .Op(op64), .Out_valid(ov64), .Out_ready(ordy64), .Sh(sh64), .Busy(busy64));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic pick_ov(input int w);
        return (w == 8) ? ov8 : (w == 32) ? ov32 : ov64;
    endfunction

    function automatic logic [63:0] pick_sh(input int w);
        return (w == 8) ? 64'(sh8) : (w == 32) ? 64'(sh32) : sh64;
    endfunction

    // Single operand through an idle pipe; checks latency to Out_valid and the result.
    task automatic xfer(input string tag, input int w, input logic [63:0] x,
                        input logic [5:0] sa, input logic [1:0] op, input logic [63:0] exp);
        int lat;
        int saw;
        saw = (w == 8) ? 3 : (w == 32) ? 5 : 6;
        @(negedge clk);
        case (w)
            8:       begin iv8  = 1; x8  = x[7:0];  sa8  = sa[2:0]; op8  = op; end
            32:      begin iv32 = 1; x32 = x[31:0]; sa32 = sa[4:0]; op32 = op; end
            default: begin iv64 = 1; x64 = x;       sa64 = sa;      op64 = op; end
        endcase
        @(negedge clk);
        iv8 = 0; iv32 = 0; iv64 = 0;
        lat = 1;
        while (!pick_ov(w) && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'(saw));
        check(tag, pick_sh(w), exp);
    endtask

    logic [31:0] bp_exp [8] = '{32'h1, 32'h4, 32'hC, 32'h20, 32'h50, 32'hC0, 32'h1C0, 32'h400};

    initial begin
        int tx, rx, cyc, stale;

        repeat (2) @(negedge clk);
        check("rst out_valid", 64'(ov32), 64'd0);
        check("rst sh",        64'(sh32), 64'd0);
        check("rst busy",      64'(busy32), 64'd0);
        check("rst in_ready",  64'(irdy32), 64'd1);
        rst_n = 1'b1;

        xfer("sll32",      32, 64'h0000_0001, 6'd2,  2'b00, 64'h0000_0004);
        xfer("sra32",      32, 64'h8000_0010, 6'd2,  2'b10, 64'hE000_0004);
        xfer("srl32",      32, 64'h8000_0010, 6'd2,  2'b01, 64'h2000_0004);
        xfer("ror32",      32, 64'h0000_0003, 6'd1,  2'b11, 64'h8000_0001);
        xfer("sll32 sa0",  32, 64'hA5A5_1234, 6'd0,  2'b00, 64'hA5A5_1234);
        xfer("srl32 sa0",  32, 64'hA5A5_1234, 6'd0,  2'b01, 64'hA5A5_1234);
        xfer("sra32 sa0",  32, 64'hA5A5_1234, 6'd0,  2'b10, 64'hA5A5_1234);
        xfer("ror32 sa0",  32, 64'hA5A5_1234, 6'd0,  2'b11, 64'hA5A5_1234);
        xfer("sll32 max",  32, 64'hFFFF_FFFF, 6'd31, 2'b00, 64'h8000_0000);
        xfer("srl32 max",  32, 64'h8000_0000, 6'd31, 2'b01, 64'h0000_0001);
        xfer("sra32 pos",  32, 64'h7FFF_FFFF, 6'd31, 2'b10, 64'h0000_0000);
        xfer("sra32 neg",  32, 64'h8000_0000, 6'd31, 2'b10, 64'hFFFF_FFFF);
        xfer("ror32 nib",  32, 64'h1234_5678, 6'd4,  2'b11, 64'h8123_4567);

        xfer("ror8",       8,  64'h81, 6'd1, 2'b11, 64'hC0);
        xfer("sra8",       8,  64'h90, 6'd3, 2'b10, 64'hF2);
        xfer("sll8",       8,  64'h0F, 6'd7, 2'b00, 64'h80);
        xfer("ror64",      64, 64'h1, 6'd63, 2'b11, 64'h2);
        xfer("sra64",      64, 64'h8000_0000_0000_0000, 6'd60, 2'b10, 64'hFFFF_FFFF_FFFF_FFF8);
        xfer("srl64",      64, 64'hF000_0000_0000_0000, 6'd33, 2'b01, 64'h0000_0000_7800_0000);

        // Back-pressure: 8 back-to-back SLLs (X=i+1, Sa=i), consumer stalls 3 cycles.
        tx = 0; rx = 0; cyc = 0;
        while (rx < 8 && cyc < 60) begin
            @(negedge clk);
            ordy32 = !(cyc >= 7 && cyc < 10);
            #1;
            if (ov32) begin
                if (ordy32) begin
                    check("bp order", 64'(sh32), 64'(bp_exp[rx]));
                    rx++;
                end else begin
                    check("bp hold", 64'(sh32), 64'(bp_exp[rx]));
                    check("bp in_ready", 64'(irdy32), 64'd0);
                end
            end
            if (tx < 8) begin
                iv32 = 1; x32 = 32'(tx + 1); sa32 = 5'(tx); op32 = 2'b00;
                if (irdy32) tx++;
            end else begin
                iv32 = 0;
            end
            cyc++;
        end
        iv32 = 0;
        ordy32 = 1;
        check("bp count", 64'(rx), 64'd8);

        // Reset with three entries in flight.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            iv32 = 1; x32 = 32'h0000_00F0 + 32'(i); sa32 = 5'd1; op32 = 2'b00;
        end
        @(negedge clk);
        iv32 = 0;
        check("inflight busy", 64'(busy32), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid-rst out_valid", 64'(ov32), 64'd0);
        check("mid-rst busy",      64'(busy32), 64'd0);
        check("mid-rst sh",        64'(sh32), 64'd0);
        check("mid-rst in_ready",  64'(irdy32), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        stale = 0;
        repeat (10) begin
            @(negedge clk);
            if (ov32) stale++;
        end
        check("post-rst stale", 64'(stale), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
